chip_counter_tester: RTL

// Parametrised tester for 7416x-family synchronous binary counters (74161/74163 and

---
 rtl/chip_counter_tester.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/chip_counter_tester.sv
// chip_counter_tester
// Tests a 7416x-family synchronous binary counter (74161/74163 and wider
// cascades). It drives the counter's control pins and clock, runs a fixed
// sequence of steps against an internal reference count, and checks Q and RCO
// just before and just after every chip clock rising edge.
//
// Ports
//   Clk        in   system clock
//   Reset      in   synchronous active-low reset
//   Run        in   start request, only honoured in HALTED
//   DISP_RSLT  in   result acknowledge, DONE_S -> HALTED
//   Q_in       in   counter outputs (WIDTH bits)
//   RCO_in     in   counter ripple-carry output
//   CLR_n      out  counter clear, active low
//   LOAD_n     out  counter parallel load, active low
//   ENP, ENT   out  counter count enables
//   CCLK       out  counter clock
//   D_out      out  counter parallel data (WIDTH bits)
//   Done       out  high while the result is being presented
//   RSLT       out  1 = pass, cleared by the first mismatch
//   Err_count  out  mismatch count, saturating at 255
//   state_dbg  out  current FSM state encoding
//
// Handshake: Run is a level request sampled only in HALTED. Done stays high in
// DONE_S with RSLT/Err_count stable until DISP_RSLT is seen high at a Clk edge;
// the FSM then returns to HALTED and may start again on Run the next cycle.
module chip_counter_tester #(
    parameter int WIDTH    = 4,
    parameter bit SYNC_CLR = 1'b0,
    parameter int SETTLE   = 2
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic             DISP_RSLT,
    input  logic [WIDTH-1:0] Q_in,
    input  logic             RCO_in,
    output logic             CLR_n,
    output logic             LOAD_n,
    output logic             ENP,
    output logic             ENT,
    output logic             CCLK,
    output logic [WIDTH-1:0] D_out,
    output logic             Done,
    output logic             RSLT,
    output logic [7:0]       Err_count,
    output logic [2:0]       state_dbg
);
    localparam int N        = 2 ** WIDTH;
    localparam int STEPS    = 2 * N + 7;
    localparam int SW       = $clog2(STEPS);
    localparam int CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    // First step index of each phase of the sequence.
    localparam int S_COUNT0 = 1;
    localparam int S_LOAD0  = N + 2;
    localparam int S_HOLDLD = 2 * N + 2;
    localparam int S_HOLD1  = 2 * N + 3;
    localparam int S_HOLD2  = 2 * N + 4;
    localparam int S_HOLD3  = 2 * N + 5;
    localparam int S_FINAL  = 2 * N + 6;

    typedef enum logic [2:0] {
        HALTED = 3'd0,
        INIT   = 3'd1,
        DRIVE  = 3'd2,
        LOW    = 3'd3,
        HIGH   = 3'd4,
        CHECK  = 3'd5,
        DONE_S = 3'd6
    } state_t;

    typedef struct packed {
        logic             clr_n;
        logic             load_n;
        logic             enp;
        logic             ent;
        logic [WIDTH-1:0] d;
    } pins_t;

    state_t           state, state_next;
    logic [SW-1:0]    step, step_next;
    logic [CW-1:0]    cnt, cnt_next;
    logic [WIDTH-1:0] qm, qm_next;
    pins_t            pins_q, pins_next;
    logic             cclk_next;
    logic             pre_edge, pre_fail, post_fail;
    logic [WIDTH-1:0] pre_exp;

    // Control pin values for one step of the sequence.
    function automatic pins_t step_pins(input logic [SW-1:0] s);
        pins_t p;
        p.clr_n  = 1'b1;
        p.load_n = 1'b1;
        p.enp    = 1'b1;
        p.ent    = 1'b1;
        p.d      = '0;
        if (s < SW'(S_COUNT0)) begin
            p.clr_n = 1'b0;
        end else if (s >= SW'(S_LOAD0) && s < SW'(S_HOLDLD)) begin
            p.load_n = 1'b0;
            p.d      = WIDTH'(s - SW'(S_LOAD0));
        end else if (s == SW'(S_HOLDLD)) begin
            p.load_n = 1'b0;
            p.d      = '1;
        end else if (s == SW'(S_HOLD1)) begin
            p.enp = 1'b0;
        end else if (s == SW'(S_HOLD2)) begin
            p.ent = 1'b0;
        end else if (s == SW'(S_HOLD3)) begin
            p.enp = 1'b0;
            p.ent = 1'b0;
        end else if (s == SW'(S_FINAL)) begin
            // Clear and load together: clear must win.
            p.clr_n  = 1'b0;
            p.load_n = 1'b0;
            p.d      = WIDTH'(5);
        end
        return p;
    endfunction

    always_comb begin
        state_next = state;
        step_next  = step;
        cnt_next   = cnt;
        case (state)
            HALTED: if (Run) state_next = INIT;
            INIT: begin
                state_next = DRIVE;
                step_next  = '0;
            end
            DRIVE: begin
                state_next = LOW;
                cnt_next   = '0;
            end
            LOW: begin
                if (cnt == CW'(SETTLE - 1)) begin
                    state_next = HIGH;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            HIGH: begin
                if (cnt == CW'(SETTLE - 1)) begin
                    state_next = CHECK;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            CHECK: begin
                if (step == SW'(STEPS - 1)) begin
                    state_next = DONE_S;
                end else begin
                    state_next = DRIVE;
                    step_next  = step + 1'b1;
                end
            end
            DONE_S: if (DISP_RSLT) state_next = HALTED;
            default: state_next = HALTED;
        endcase
    end

    // Pins are registered from the next state so CCLK comes straight off a
    // flop and cannot glitch on state decode.
    always_comb begin
        pins_next = '0;
        cclk_next = 1'b0;
        if (state_next == DRIVE || state_next == LOW ||
            state_next == HIGH  || state_next == CHECK) begin
            pins_next = step_pins(step_next);
        end
        if (state_next == HIGH || state_next == CHECK) begin
            cclk_next = 1'b1;
        end
    end

    // Reference counter: value after the coming CCLK rise.
    always_comb begin
        qm_next = qm;
        if (!pins_q.clr_n) begin
            qm_next = '0;
        end else if (!pins_q.load_n) begin
            qm_next = pins_q.d;
        end else if (pins_q.enp && pins_q.ent) begin
            qm_next = qm + 1'b1;
        end
    end

    // The last LOW cycle is both the pre-edge sample point and the Clk edge
    // on which CCLK rises, so the model advances on that same edge.
    assign pre_edge  = (state == LOW) && (cnt == CW'(SETTLE - 1));
    // An asynchronous-clear part must already read zero while CLR_n is low.
    assign pre_exp   = (!SYNC_CLR && !pins_q.clr_n) ? '0 : qm;
    assign pre_fail  = pre_edge && (Q_in != pre_exp);
    assign post_fail = (state == CHECK) &&
                       ((Q_in != qm) || (RCO_in != (pins_q.ent & (&qm))));

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state     <= HALTED;
            step      <= '0;
            cnt       <= '0;
            qm        <= '0;
            pins_q    <= '0;
            CCLK      <= 1'b0;
            RSLT      <= 1'b0;
            Err_count <= 8'd0;
        end else begin
            state  <= state_next;
            step   <= step_next;
            cnt    <= cnt_next;
            pins_q <= pins_next;
            CCLK   <= cclk_next;
            if (state == INIT) begin
                RSLT      <= 1'b1;
                Err_count <= 8'd0;
                qm        <= '0;
            end else begin
                if (pre_edge) qm <= qm_next;
                if (pre_fail || post_fail) begin
                    RSLT <= 1'b0;
                    if (Err_count != 8'hFF) Err_count <= Err_count + 8'd1;
                end
            end
        end
    end

    assign CLR_n     = pins_q.clr_n;
    assign LOAD_n    = pins_q.load_n;
    assign ENP       = pins_q.enp;
    assign ENT       = pins_q.ent;
    assign D_out     = pins_q.d;
    assign Done      = (state == DONE_S);
    assign state_dbg = state;

endmodule
